// File: rtl/fpu_pkg.sv
// Shared encodings and format constants for the FP compare scheduler.
// Exponent/mantissa widths are derived from the operand bus width.
package fpu_pkg;

  typedef enum logic [1:0] {
    FCMP_FEQ  = 2'b00,
    FCMP_FLT  = 2'b01,
    FCMP_FLE  = 2'b10,
    FCMP_RSVD = 2'b11
  } fcmp_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } fcmp_state_e;

  localparam int EXP_W_D = 11;
  localparam int MAN_W_D = 52;
  localparam int EXP_W_S = 8;
  localparam int MAN_W_S = 23;

  localparam logic [EXP_W_D-1:0] EXP_ONES_D = '1;
  localparam logic [EXP_W_S-1:0] EXP_ONES_S = '1;

  function automatic int fcmp_exp_w(input int bw);
    return (bw == 32) ? EXP_W_S : EXP_W_D;
  endfunction

  function automatic int fcmp_man_w(input int bw);
    return (bw == 32) ? MAN_W_S : MAN_W_D;
  endfunction

endpackage

// File: rtl/fcmp_core.sv
// Combinational RISC-V FEQ/FLT/FLE core: NaN-masked lt/eq plus the NV flag for the op.
// Only BUS_WIDTH 32 (binary32) and 64 (binary64) are meaningful.
module fcmp_core
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH = 64
) (
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  input  fcmp_op_e             op,
  output logic                 lt,
  output logic                 eq,
  output logic                 nv
);

  localparam int EW = fcmp_exp_w(BUS_WIDTH);
  localparam int MW = fcmp_man_w(BUS_WIDTH);
  localparam logic [EW-1:0] EXP_ONES = (BUS_WIDTH == 32) ? EW'(EXP_ONES_S) : EW'(EXP_ONES_D);

  logic          a_s, b_s;
  logic [EW-1:0] a_e, b_e;
  logic [MW-1:0] a_m, b_m;
  logic          a_nan, b_nan, a_snan, b_snan, any_nan, any_snan;
  logic          both_zero, mag_lt, mag_gt, raw_lt, raw_eq;

  always_comb begin
    a_s = in1[BUS_WIDTH-1];
    b_s = in2[BUS_WIDTH-1];
    a_e = in1[BUS_WIDTH-2 -: EW];
    b_e = in2[BUS_WIDTH-2 -: EW];
    a_m = in1[MW-1:0];
    b_m = in2[MW-1:0];

    a_nan    = (a_e == EXP_ONES) && (a_m != '0);
    b_nan    = (b_e == EXP_ONES) && (b_m != '0);
    a_snan   = a_nan && !a_m[MW-1];
    b_snan   = b_nan && !b_m[MW-1];
    any_nan  = a_nan | b_nan;
    any_snan = a_snan | b_snan;

    // {e,m} as an unsigned integer orders magnitudes for IEEE formats
    both_zero = (in1[BUS_WIDTH-2:0] == '0) && (in2[BUS_WIDTH-2:0] == '0);
    mag_lt    = in1[BUS_WIDTH-2:0] < in2[BUS_WIDTH-2:0];
    mag_gt    = in1[BUS_WIDTH-2:0] > in2[BUS_WIDTH-2:0];

    raw_eq = (in1 == in2) || both_zero;
    if (both_zero)       raw_lt = 1'b0;
    else if (a_s != b_s) raw_lt = a_s;
    else if (!a_s)       raw_lt = mag_lt;
    else                 raw_lt = mag_gt;

    lt = !any_nan && raw_lt;
    eq = !any_nan && raw_eq;

    case (op)
      FCMP_FEQ:          nv = any_snan;
      FCMP_FLT, FCMP_FLE: nv = any_nan;
      default:           nv = 1'b0;
    endcase
  end

endmodule

// File: rtl/fcmp_scheduler.sv
// Two-requester round-robin front end sharing one FP compare core.
// IDLE accepts one op, EXEC evaluates, RESP holds the response until taken.
module fcmp_scheduler
  import fpu_pkg::*;
#(
  parameter int BUS_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [1:0]           req0_op,
  input  logic [BUS_WIDTH-1:0] req0_in1,
  input  logic [BUS_WIDTH-1:0] req0_in2,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [1:0]           req1_op,
  input  logic [BUS_WIDTH-1:0] req1_in1,
  input  logic [BUS_WIDTH-1:0] req1_in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_id,
  output logic [BUS_WIDTH-1:0] out_result,
  output logic                 out_nv
);

  typedef struct packed {
    fcmp_op_e             op;
    logic [BUS_WIDTH-1:0] in1;
    logic [BUS_WIDTH-1:0] in2;
    logic                 id;
  } req_t;

  fcmp_state_e state, state_nxt;
  req_t        req_r;
  logic        rr_ptr, res_r, nv_r;
  logic        grant, accept, deliver, cmp_bit;
  logic        core_lt, core_eq, core_nv;

  fcmp_core #(.BUS_WIDTH(BUS_WIDTH)) u_core (
    .in1 (req_r.in1),
    .in2 (req_r.in2),
    .op  (req_r.op),
    .lt  (core_lt),
    .eq  (core_eq),
    .nv  (core_nv)
  );

  always_comb begin
    grant      = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
    // ready is masked during reset so nothing looks accepted while flops are held
    accept     = (state == IDLE) && (req0_valid || req1_valid) && !rst;
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    deliver    = (state == RESP) && out_ready;

    case (req_r.op)
      FCMP_FEQ: cmp_bit = core_eq;
      FCMP_FLT: cmp_bit = core_lt;
      FCMP_FLE: cmp_bit = core_lt | core_eq;
      default:  cmp_bit = 1'b0;
    endcase

    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = EXEC;
      EXEC:                 state_nxt = RESP;
      RESP:    if (deliver) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
      req_r  <= '0;
      res_r  <= 1'b0;
      nv_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_r.op  <= grant ? fcmp_op_e'(req1_op) : fcmp_op_e'(req0_op);
        req_r.in1 <= grant ? req1_in1 : req0_in1;
        req_r.in2 <= grant ? req1_in2 : req0_in2;
        req_r.id  <= grant;
      end
      if (state == EXEC) begin
        res_r <= cmp_bit;
        nv_r  <= core_nv;
      end
      if (deliver) rr_ptr <= ~req_r.id;
    end
  end

  assign out_valid  = (state == RESP);
  assign out_id     = req_r.id;
  assign out_result = {{(BUS_WIDTH-1){1'b0}}, res_r};
  assign out_nv     = nv_r;

endmodule

// File: tb/tb_fcmp_scheduler.sv
// Directed bench for fcmp_scheduler (binary64): vector table plus arbitration,
// back-pressure and mid-op reset sequences.
module tb_fcmp_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [63:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic        out_valid, out_ready, out_id, out_nv;
  logic [63:0] out_result;

  int n_cmp = 0;
  int n_bad = 0;

  fcmp_scheduler #(.BUS_WIDTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_in1   (req0_in1),
    .req0_in2   (req0_in2),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_in1   (req1_in1),
    .req1_in2   (req1_in2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_result (out_result),
    .out_nv     (out_nv)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] P1   = 64'h3FF0000000000000;
  localparam logic [63:0] P2   = 64'h4000000000000000;
  localparam logic [63:0] N1   = 64'hBFF0000000000000;
  localparam logic [63:0] N2   = 64'hC000000000000000;
  localparam logic [63:0] PZ   = 64'h0000000000000000;
  localparam logic [63:0] NZ   = 64'h8000000000000000;
  localparam logic [63:0] QNAN = 64'h7FF8000000000000;
  localparam logic [63:0] SNAN = 64'h7FF0000000000001;
  localparam logic [63:0] PINF = 64'h7FF0000000000000;

  typedef struct {
    logic        rq;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        res;
    logic        nv;
  } vec_t;

  vec_t tv[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic drive(input logic rq, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    if (rq) begin
      req1_valid = 1'b1; req1_op = op; req1_in1 = a; req1_in2 = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_in1 = a; req0_in2 = b;
    end
  endtask

  // full single-requester transaction with fixed-latency checks
  task automatic run_op(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    drive(v.rq, v.op, v.a, v.b);
    #1;
    check({tag, " ready"}, v.rq ? req1_ready : req0_ready, 1);
    check({tag, " other_ready"}, v.rq ? req0_ready : req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 2'b11; req1_op = 2'b11;
    req0_in1 = ~v.a; req0_in2 = ~v.b; req1_in1 = ~v.a; req1_in2 = ~v.b;
    check({tag, " exec_valid"}, out_valid, 0);
    tick();
    check({tag, " valid"}, out_valid, 1);
    check({tag, " id"}, out_id, v.rq);
    check({tag, " result"}, out_result, {63'd0, v.res});
    check({tag, " nv"}, out_nv, v.nv);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " after_xfer"}, out_valid, 0);
  endtask

  initial begin
    int got, last, cnt;

    tv[0]  = '{1'b0, 2'b01, P1,   P2,   1'b1, 1'b0};
    tv[1]  = '{1'b1, 2'b00, PZ,   NZ,   1'b1, 1'b0};
    tv[2]  = '{1'b1, 2'b01, PZ,   NZ,   1'b0, 1'b0};
    tv[3]  = '{1'b1, 2'b10, PZ,   NZ,   1'b1, 1'b0};
    tv[4]  = '{1'b0, 2'b00, QNAN, P1,   1'b0, 1'b0};
    tv[5]  = '{1'b1, 2'b00, SNAN, P1,   1'b0, 1'b1};
    tv[6]  = '{1'b0, 2'b10, QNAN, P1,   1'b0, 1'b1};
    tv[7]  = '{1'b1, 2'b01, N2,   N1,   1'b1, 1'b0};
    tv[8]  = '{1'b0, 2'b11, P1,   P2,   1'b0, 1'b0};
    tv[9]  = '{1'b0, 2'b01, P2,   P1,   1'b0, 1'b0};
    tv[10] = '{1'b1, 2'b10, P1,   P1,   1'b1, 1'b0};
    tv[11] = '{1'b0, 2'b01, N1,   P1,   1'b1, 1'b0};
    tv[12] = '{1'b1, 2'b01, N1,   N2,   1'b0, 1'b0};
    tv[13] = '{1'b0, 2'b10, PZ,   N1,   1'b0, 1'b0};
    tv[14] = '{1'b1, 2'b00, PINF, PINF, 1'b1, 1'b0};
    tv[15] = '{1'b0, 2'b01, P1,   PINF, 1'b1, 1'b0};
    tv[16] = '{1'b1, 2'b01, P1,   QNAN, 1'b0, 1'b1};

    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0; out_ready = 1'b0;
    req0_op = 2'b01; req1_op = 2'b00;
    req0_in1 = P1; req0_in2 = P2; req1_in1 = '0; req1_in2 = '0;
    #12;
    check("reset req0_ready", req0_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_id", out_id, 0);
    check("reset out_result", out_result, 0);
    check("reset out_nv", out_nv, 0);
    do_reset();

    for (int i = 0; i < 17; i++) run_op(i, tv[i]);

    // both requesters continuously valid: alternating grants, 3-cycle spacing
    do_reset();
    drive(1'b0, 2'b00, P1, P1);
    drive(1'b1, 2'b00, P1, P1);
    out_ready = 1'b1;
    #1;
    check("rr first grant0", req0_ready, 1);
    check("rr first grant1", req1_ready, 0);
    got = 0; last = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      tick();
      if (out_valid) begin
        check($sformatf("rr id%0d", got), out_id, got % 2);
        if (got > 0) check($sformatf("rr gap%0d", got), c - last, 3);
        last = c;
        got++;
      end
    end
    check("rr resp count", got, 6);

    // back-pressure: response held, no accepts while in RESP
    do_reset();
    drive(1'b0, 2'b01, P1, P2);
    tick();
    req0_valid = 1'b0;
    tick();
    drive(1'b0, 2'b00, P2, P2);
    drive(1'b1, 2'b00, P2, P2);
    #1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp valid c%0d", c), out_valid, 1);
      check($sformatf("bp result c%0d", c), out_result, 64'd1);
      check($sformatf("bp id c%0d", c), out_id, 0);
      check($sformatf("bp ready0 c%0d", c), req0_ready, 0);
      check($sformatf("bp ready1 c%0d", c), req1_ready, 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp release valid", out_valid, 1);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (out_valid) cnt++;
    end
    check("bp single transfer", cnt, 0);
    out_ready = 1'b0;

    // reset during EXEC: op dropped, rr_ptr back to 0
    do_reset();
    run_op(100, tv[0]);
    drive(1'b0, 2'b01, P1, P2);
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rstexec out_valid", out_valid, 0);
    check("rstexec out_id", out_id, 0);
    check("rstexec out_result", out_result, 0);
    check("rstexec out_nv", out_nv, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (out_valid) cnt++;
    end
    check("rstexec no response", cnt, 0);
    out_ready = 1'b0;
    drive(1'b0, 2'b00, P1, P1);
    drive(1'b1, 2'b00, P1, P1);
    #1;
    check("rstexec rr grant0", req0_ready, 1);
    check("rstexec rr grant1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
